// File: rtl/pwm_capture.sv
// pwm_capture: measures the high width and rising-to-rising period of a PWM input in clk cycles.
// Latency: valid pulses SYNC_STAGES+1 cycles after the closing pwm_in rise; no backpressure, valid is a one-cycle strobe.
module pwm_capture #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             lost
);

  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic                   at_to;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] hi_cnt, hi_cnt_n;
  logic [CNT_W-1:0] width_n, period_n;
  logic             valid_n, lost_n;

  // Synchronizer runs independently of en so edges are clean when capture resumes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_d  <= s;
    end
  end

  assign s     = sync[SYNC_STAGES-1];
  assign rise  = s & ~s_d;
  assign fall  = ~s & s_d;
  assign at_to = (cnt == TO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_cnt <= '0;
      width  <= '0;
      period <= '0;
      valid  <= 1'b0;
      lost   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      hi_cnt <= hi_cnt_n;
      width  <= width_n;
      period <= period_n;
      valid  <= valid_n;
      lost   <= lost_n;
    end
  end

  // Edges take priority over the timeout, so a period of exactly TIMEOUT still measures.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hi_cnt_n = hi_cnt;
    width_n  = width;
    period_n = period;
    valid_n  = 1'b0;
    lost_n   = lost;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      lost_n  = 1'b0;
    end else begin
      if (rise)       cnt_n = ONE;
      else if (!at_to) cnt_n = cnt + ONE;
      case (state)
        IDLE: begin
          if (rise) state_n = HIGH;
        end
        HIGH: begin
          if (fall) begin
            hi_cnt_n = cnt;
            state_n  = LOW;
          end else if (at_to) begin
            state_n = IDLE;
            lost_n  = 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            width_n  = hi_cnt;
            period_n = cnt;
            valid_n  = 1'b1;
            lost_n   = 1'b0;
            state_n  = HIGH;
          end else if (at_to) begin
            state_n = IDLE;
            lost_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a short TIMEOUT so every scenario fits in a brief run.
module tb_pwm_capture;

  localparam int CNT_W = 24;
  localparam int SS    = 2;
  localparam int TO    = 10_000;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             pwm_in;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             lost;

  int cyc = 0;
  int rise_m = 0;
  int vcount = 0;
  int vw = 0, vp = 0, vlat = 0;
  int checks = 0, failures = 0;
  int m, v0, v1;

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
    .width(width), .period(period), .valid(valid), .lost(lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Valid monitor: counts strobes and captures outputs and latency from the last pwm_in rise.
  always @(negedge clk) begin
    if (valid) begin
      vcount = vcount + 1;
      vw     = 32'(width);
      vp     = 32'(period);
      vlat   = cyc - rise_m;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; pwm_in high for hi cycles, next rise per cycles later.
  task automatic pulse(input int hi, input int per);
    pwm_in = 1'b1;
    rise_m = cyc;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (per - hi) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_width", 32'(width), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_lost", 32'(lost), 0);
    rst = 1'b0;
    @(negedge clk);

    // en low: nothing measured
    repeat (3) pulse(50, 200);
    chk("dis_vcount", vcount, 0);
    chk("dis_width", 32'(width), 0);
    chk("dis_period", 32'(period), 0);
    chk("dis_lost", 32'(lost), 0);

    // steady train
    en = 1'b1;
    pulse(50, 200);
    chk("first_rise_novalid", vcount, 0);
    repeat (3) pulse(50, 200);
    chk("train_vcount", vcount, 3);
    chk("train_width", vw, 50);
    chk("train_period", vp, 200);
    chk("train_latency", vlat, SS + 1);

    // change high time, then period
    pulse(100, 200);
    pulse(100, 300);
    chk("chg_width", vw, 100);
    chk("chg_period", vp, 200);
    pulse(100, 300);
    chk("chg2_period", vp, 300);
    chk("chg2_vcount", vcount, 6);

    // minimum width, then loss while low
    pulse(1, 1000);
    pulse(1, 1000);
    chk("min_width", vw, 1);
    chk("min_period", vp, 1000);
    m = rise_m;
    while (cyc < m + TO + SS) @(negedge clk);
    chk("lost_low_early", 32'(lost), 0);
    @(negedge clk);
    chk("lost_low", 32'(lost), 1);
    chk("lost_hold_width", 32'(width), 1);
    chk("lost_hold_period", 32'(period), 1000);
    v0 = vcount;
    pulse(1, 1000);
    chk("lost_first_rise", 32'(lost), 1);
    chk("lost_first_novalid", vcount, v0);
    pulse(1, 1000);
    chk("lost_cleared", 32'(lost), 0);
    chk("resume_vcount", vcount, v0 + 1);
    chk("resume_period", vp, 1000);

    // stuck high
    pwm_in = 1'b1;
    rise_m = cyc;
    m = cyc;
    while (cyc < m + TO + SS) @(negedge clk);
    chk("lost_high_early", 32'(lost), 0);
    @(negedge clk);
    chk("lost_high", 32'(lost), 1);
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);
    v0 = vcount;

    // period exactly TIMEOUT: edge beats timeout
    pulse(1, TO);
    chk("maxp_first_novalid", vcount, v0);
    pulse(1, TO);
    chk("maxp_vcount", vcount, v0 + 1);
    chk("maxp_period", vp, TO);
    chk("maxp_width", vw, 1);
    chk("maxp_lost", 32'(lost), 0);

    // reset mid-high
    pulse(50, 200);
    pulse(50, 200);
    chk("pre_rst_width", 32'(width), 50);
    pwm_in = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_width", 32'(width), 0);
    chk("arst_period", 32'(period), 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_lost", 32'(lost), 0);
    pwm_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // en dropped mid-low
    pulse(40, 200);
    pulse(40, 200);
    chk("post_rst_width", vw, 40);
    pwm_in = 1'b1;
    rise_m = cyc;
    repeat (50) @(negedge clk);
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);
    en = 1'b0;
    repeat (130) @(negedge clk);
    v1 = vcount;
    pulse(50, 200);
    chk("en_off_novalid", vcount, v1);
    chk("en_off_width_hold", 32'(width), 40);
    chk("en_off_lost", 32'(lost), 0);
    en = 1'b1;
    pulse(70, 200);
    chk("en_on_first_novalid", vcount, v1);
    pulse(30, 200);
    chk("en_on_second_valid", vcount, v1 + 1);
    chk("en_on_width", vw, 70);
    chk("en_on_period", vp, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming servo-style PWM signal and reports high-pulse width and period in clk cycles.
- It is the receive-side counterpart of the servo pwm generator, whose `angle` input is also a pulse width in clk cycles.
- Uses: loopback checks of the generator and reading external RC/servo command signals.
- A new measurement is published once per full period, with a one-cycle valid strobe.

Parameters:
- CNT_W, 24, width of all counters and of the width/period outputs.
- SYNC_STAGES, 2, number of input synchronizer flops (minimum 2).
- TIMEOUT, 4_000_000, cycles without an expected edge before the signal is declared lost (40 ms at 100 MHz). Must be < 2^CNT_W.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-high reset
- en  in  1  capture enable
- pwm_in  in  1  asynchronous PWM input
- width  out  CNT_W  last measured high time, in clk cycles
- period  out  CNT_W  last measured rising-to-rising time, in clk cycles
- valid  out  1  one-cycle strobe; width/period updated this cycle
- lost  out  1  level; signal stuck high or low for TIMEOUT cycles

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - width=0, period=0, valid=0, lost=0.
  - State IDLE; cnt=0 and hi_cnt=0.
  - All synchronizer flops and s_d = 0.
- Input conditioning:
  - pwm_in passes through SYNC_STAGES flops to give s; s_d is s delayed one cycle.
  - The synchronizer runs regardless of en.
  - rise = s & ~s_d; fall = ~s & s_d.
- Counter cnt:
  - Set to 1 on rise (any state except when en=0).
  - Otherwise increments by 1 each cycle, saturating at TIMEOUT.
  - hi_cnt holds the captured high time.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: wait for rise, then go to HIGH with cnt<=1. No output update. An input already high when en rises is ignored until the next rise.
  - HIGH: on fall, hi_cnt<=cnt and go to LOW. If cnt==TIMEOUT with no fall this cycle, go to IDLE and set lost<=1.
  - LOW: on rise, width<=hi_cnt, period<=cnt, valid<=1, lost<=0, cnt<=1, go to HIGH. If cnt==TIMEOUT with no rise this cycle, go to IDLE and set lost<=1.
- Exactness: a pulse high for N cycles with rising edges P cycles apart yields width=N and period=P exactly. Minimum width=1; maximum period=TIMEOUT.
- Priority: an edge in the same cycle that cnt reaches TIMEOUT wins; the edge is processed and no timeout is raised.
- Valid timing:
  - The first rise after reset, en-assert or timeout produces no valid, since a full period is needed.
  - Let edge k be the first clk edge sampling pwm_in=1 for the closing rise. valid is high in the cycle after edge k+SYNC_STAGES, for exactly one cycle.
- Output holding: width/period hold their values between updates, across timeout and across en=0. lost holds until the next valid.
- en=0 (synchronous, highest priority after rst): state<=IDLE, cnt<=0, valid<=0, lost<=0. width/period hold.
- Reset mid-pulse: all outputs clear immediately (asynchronous). Measurement restarts from IDLE after release.

Test Plan:
1. rst pulse, en=0, 50_000-high/2_000_000-period train for 3 periods -> valid never asserts; width=period=lost=0.
2. en=1, same train -> no valid on first rise; valid one cycle at each later rise with width=50_000, period=2_000_000; valid exactly SYNC_STAGES+1 cycles after the pwm_in rise.
3. Switch high time to 100_000 mid-stream -> next valid after the changed pulse reports width=100_000, period=2_000_000. Then change period to 1_500_000 and check it is reported on the next valid.
4. TIMEOUT=10_000, period 1000, high 1 -> width=1, period=1000. Then hold pwm_in low -> lost=1 exactly 10_000 cycles after the last s rise; width/period hold 1/1000. Resume -> lost stays 1 through the first rise and clears with the valid at the second rise.
5. TIMEOUT=10_000, hold pwm_in high -> lost=1 after 10_000 cycles in HIGH. Period exactly 10_000 -> valid with period=10_000, lost=0 (edge beats timeout).
6. Assert rst mid-HIGH -> width/period/valid/lost go 0 before the next clk edge. Deassert en mid-LOW -> no valid at the next rise; first valid two rises after en returns high.
